// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response signals of the shared-ALU arbiter
interface alu_arbiter_if #(parameter int XLEN = 32);
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]      req0_ctrl, req1_ctrl, alu_ctrl;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [XLEN-1:0] alu_a, alu_b, alu_out, rsp_data;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    input  alu_out, rsp_ready,
    output req0_ready, req1_ready, alu_ctrl, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, busy
  );
  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    output alu_out, rsp_ready,
    input  req0_ready, req1_ready, alu_ctrl, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with valid/ready handshakes
module alu_arbiter #(
  parameter int XLEN  = 32,
  parameter bit RR_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t          state_q, state_d;
  logic            last_q, last_d, err_q, err_d, id_q, id_d;
  logic            vld_q, vld_d, zero_q, zero_d, rerr_q, rerr_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic            idle, gnt1;
  logic [3:0]      sel_ctrl;
  assign idle           = state_q == IDLE;
  assign gnt1           = bus.req1_valid & (~bus.req0_valid | (RR_EN & ~last_q));
  assign sel_ctrl       = gnt1 ? bus.req1_ctrl : bus.req0_ctrl;
  assign bus.req0_ready = idle & ~rst & bus.req0_valid & ~gnt1;
  assign bus.req1_ready = idle & ~rst & gnt1;
  assign bus.alu_ctrl   = ctrl_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.rsp_valid  = vld_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = rerr_q;
  assign bus.busy       = ~idle;
  // next state: accept in IDLE, capture the ALU result in EXEC, release on the response handshake
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    err_d   = err_q;
    id_d    = id_q;
    vld_d   = vld_q;
    zero_d  = zero_q;
    rerr_d  = rerr_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    if (idle && (bus.req0_valid || bus.req1_valid)) begin
      state_d = EXEC;
      ctrl_d  = sel_ctrl;
      a_d     = gnt1 ? bus.req1_a : bus.req0_a;
      b_d     = gnt1 ? bus.req1_b : bus.req0_b;
      id_d    = gnt1;
      last_d  = gnt1;
      err_d   = !(sel_ctrl inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12});
    end
    if (state_q == EXEC) begin
      state_d = RESP;
      data_d  = bus.alu_out;
      zero_d  = bus.alu_out == '0;
      rerr_d  = err_q;
      vld_d   = 1'b1;
    end
    if (state_q == RESP && bus.rsp_ready) begin
      state_d = IDLE;
      vld_d   = 1'b0;
    end
  end
  // one register bank; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      id_q    <= 1'b0;
      vld_q   <= 1'b0;
      zero_q  <= 1'b0;
      rerr_q  <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      err_q   <= err_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      zero_q  <= zero_d;
      rerr_q  <= rerr_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end
endmodule
